// File: rtl/uart_tx_feeder_if.sv
// Bundles the producer write port and the transmitter handshake of the UART TX feeder.
// The master side is the producer/transmitter pair; the slave side is the feeder itself.
interface uart_tx_feeder_if #(
    parameter int D_BIT  = 8,
    parameter int ADDR_W = 4
);
    logic              wr_en;
    logic [D_BIT-1:0]  wr_data;
    logic              full;
    logic              empty;
    logic [ADDR_W:0]   count;
    logic              overflow;
    logic              tx_done;
    logic              tx_start;
    logic [D_BIT-1:0]  d_out;
    logic              busy;

    modport master (
        output wr_en, wr_data, tx_done,
        input  full, empty, count, overflow, tx_start, d_out, busy
    );

    modport slave (
        input  wr_en, wr_data, tx_done,
        output full, empty, count, overflow, tx_start, d_out, busy
    );
endinterface

// File: rtl/uart_tx_feeder.sv
// Circular byte FIFO plus launch sequencer sitting in front of the UART transmitter.
// One byte is presented at a time and the next is launched only after the frame completes.
//
// state    | meaning
// IDLE     | no byte in flight; launches the FIFO head as soon as the FIFO is non-empty
// SEND     | tx_start high, d_out frozen; waits for the rising edge of tx_done
// WAIT_CLR | frame finished; waits for tx_done to drop before the next launch
module uart_tx_feeder #(
    parameter int D_BIT  = 8,
    parameter int ADDR_W = 4
) (
    input  logic            clk,
    input  logic            reset,
    uart_tx_feeder_if.slave bus
);
    localparam int              DEPTH      = 1 << ADDR_W;
    localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] CNT_ONE    = (ADDR_W+1)'(1);

    typedef enum logic [2:0] {
        IDLE     = 3'b001,
        SEND     = 3'b010,
        WAIT_CLR = 3'b100
    } state_t;

    state_t              state;
    state_t              state_nxt;

    logic [D_BIT-1:0]    mem [DEPTH];
    logic [ADDR_W-1:0]   rd_ptr;
    logic [ADDR_W-1:0]   wr_ptr;
    logic [ADDR_W:0]     count;
    logic                overflow;
    logic                tx_start;
    logic [D_BIT-1:0]    d_out;
    logic                tx_done_q;

    logic                full;
    logic                empty;
    logic                push;
    logic                pop;
    logic                done_rise;

    assign full      = (count == FULL_COUNT);
    assign empty     = (count == '0);
    // A write while full is dropped even if a pop happens in the same cycle.
    assign push      = bus.wr_en & ~full;
    assign done_rise = bus.tx_done & ~tx_done_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop       = 1'b1;
                    state_nxt = SEND;
                end
            end
            SEND: begin
                if (done_rise) begin
                    state_nxt = WAIT_CLR;
                end
            end
            WAIT_CLR: begin
                if (!bus.tx_done) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Storage is not reset; occupancy and pointers define which entries are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            tx_start  <= 1'b0;
            d_out     <= '0;
            tx_done_q <= 1'b0;
        end else begin
            tx_done_q <= bus.tx_done;
            tx_start  <= (state_nxt == SEND);

            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                d_out  <= mem[rd_ptr];
            end

            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase

            if (bus.wr_en && full) begin
                overflow <= 1'b1;
            end
        end
    end

    assign bus.full     = full;
    assign bus.empty    = empty;
    assign bus.count    = count;
    assign bus.overflow = overflow;
    assign bus.tx_start = tx_start;
    assign bus.d_out    = d_out;
    assign bus.busy     = (state != IDLE);
endmodule

// File: tb/tb_uart_tx_feeder.sv
// Directed-plus-random bench for uart_tx_feeder: queue-based expected byte order,
// a behavioural transmitter that pulses tx_done, and hand-driven corner cases.
module tb_uart_tx_feeder;
    localparam int D_BIT  = 8;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 16;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    uart_tx_feeder_if #(.D_BIT(D_BIT), .ADDR_W(ADDR_W)) bus ();

    uart_tx_feeder #(.D_BIT(D_BIT), .ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic auto_done = 1'b0;
    logic man_done  = 1'b0;
    assign bus.tx_done = auto_done | man_done;

    int   checks   = 0;
    int   errors   = 0;
    bit   xmit_on  = 1'b0;
    int   launches = 0;
    logic [7:0] launched [$];
    logic [7:0] exp_q [$];
    logic       mon_prev = 1'b0;
    logic [7:0] mon_cur  = 8'h00;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Launch monitor: logs each byte at its tx_start rise and checks d_out holds during the frame.
    initial begin
        forever begin
            @(negedge clk);
            if (bus.tx_start && !mon_prev) begin
                launched.push_back(bus.d_out);
                launches++;
                mon_cur = bus.d_out;
            end else if (bus.tx_start) begin
                check("d_out_hold", 32'(bus.d_out), 32'(mon_cur));
            end
            mon_prev = bus.tx_start;
        end
    end

    // Behavioural transmitter: random start delay, tx_done high for two clocks.
    initial begin
        forever begin
            @(negedge clk);
            if (xmit_on && bus.tx_start) begin
                repeat ($urandom_range(0, 2)) @(negedge clk);
                auto_done = 1'b1;
                @(negedge clk);
                check("tx_start_fall", 32'(bus.tx_start), 0);
                @(negedge clk);
                auto_done = 1'b0;
                @(negedge clk);
                check("no_early_restart", 32'(bus.tx_start), 0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic do_reset();
        reset       = 1'b1;
        bus.wr_en   = 1'b0;
        bus.wr_data = 8'h00;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        launched.delete();
        exp_q.delete();
        launches = 0;
    endtask

    task automatic write_byte(input logic [7:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_data = d;
        @(negedge clk);
        bus.wr_en   = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while (!(bus.empty && !bus.busy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(n < budget), 1);
    endtask

    task automatic compare_order(input string tag);
        check({tag, "_n"}, 32'(launched.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < launched.size()) begin
                check(tag, 32'(launched[i]), 32'(exp_q[i]));
            end
        end
    endtask

    logic [7:0] data [17];
    int         snap;

    initial begin
        bus.wr_en   = 1'b0;
        bus.wr_data = 8'h00;

        // Single byte, hand-driven tx_done
        do_reset();
        check("rst_empty", 32'(bus.empty), 1);
        check("rst_full", 32'(bus.full), 0);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_count", 32'(bus.count), 0);
        check("rst_overflow", 32'(bus.overflow), 0);
        check("rst_tx_start", 32'(bus.tx_start), 0);
        check("rst_d_out", 32'(bus.d_out), 0);
        write_byte(8'hA5);
        check("t1_empty", 32'(bus.empty), 0);
        check("t1_count1", 32'(bus.count), 1);
        check("t1_not_yet", 32'(bus.tx_start), 0);
        @(negedge clk);
        check("t1_start", 32'(bus.tx_start), 1);
        check("t1_d_out", 32'(bus.d_out), 32'h A5);
        check("t1_count0", 32'(bus.count), 0);
        check("t1_busy", 32'(bus.busy), 1);
        man_done = 1'b1;
        @(negedge clk);
        check("t1_start_fall", 32'(bus.tx_start), 0);
        check("t1_busy_wait", 32'(bus.busy), 1);
        @(negedge clk);
        check("t1_busy_hold", 32'(bus.busy), 1);
        man_done = 1'b0;
        @(negedge clk);
        check("t1_idle", 32'(bus.busy), 0);
        check("t1_launches", 32'(launches), 1);
        // Spurious done while idle
        man_done = 1'b1;
        repeat (2) @(negedge clk);
        man_done = 1'b0;
        repeat (3) @(negedge clk);
        check("t1_spurious_busy", 32'(bus.busy), 0);
        check("t1_spurious_launch", 32'(launches), 1);

        // Three back-to-back bytes through the transmitter model
        do_reset();
        xmit_on = 1'b1;
        exp_q = '{8'h11, 8'h22, 8'h33};
        write_byte(8'h11);
        write_byte(8'h22);
        write_byte(8'h33);
        wait_idle("t2_drain", 200);
        compare_order("t2_order");
        check("t2_empty", 32'(bus.empty), 1);
        xmit_on = 1'b0;
        repeat (4) @(negedge clk);

        // Fill under a stalled transmitter, then one write too many
        do_reset();
        for (int i = 0; i < 17; i++) begin
            data[i] = 8'($urandom);
            write_byte(data[i]);
        end
        check("t3_count16", 32'(bus.count), DEPTH);
        check("t3_full", 32'(bus.full), 1);
        check("t3_no_ovf", 32'(bus.overflow), 0);
        check("t3_first_out", 32'(bus.d_out), 32'(data[0]));
        write_byte(8'($urandom));
        check("t3_ovf", 32'(bus.overflow), 1);
        check("t3_count_kept", 32'(bus.count), DEPTH);

        // Write while full in the same cycle as the launch pop
        do_reset();
        for (int i = 0; i < 17; i++) begin
            data[i] = 8'($urandom);
            exp_q.push_back(data[i]);
            write_byte(data[i]);
        end
        check("t4_ovf0", 32'(bus.overflow), 0);
        man_done = 1'b1;
        @(negedge clk);
        man_done = 1'b0;
        @(negedge clk);
        check("t4_idle_full", 32'(bus.full), 1);
        write_byte(8'($urandom));
        check("t4_count15", 32'(bus.count), DEPTH - 1);
        check("t4_ovf1", 32'(bus.overflow), 1);
        check("t4_start", 32'(bus.tx_start), 1);
        check("t4_second", 32'(bus.d_out), 32'(data[1]));
        xmit_on = 1'b1;
        wait_idle("t4_drain", 400);
        compare_order("t4_order");

        // Random-gap stream that wraps both pointers
        do_reset();
        for (int i = 0; i < 20; i++) begin
            logic [7:0] d;
            d = 8'($urandom);
            exp_q.push_back(d);
            write_byte(d);
            repeat ($urandom_range(2, 6)) @(negedge clk);
        end
        wait_idle("t5_drain", 400);
        compare_order("t5_order");
        check("t5_no_ovf", 32'(bus.overflow), 0);
        check("t5_count", 32'(bus.count), 0);
        xmit_on = 1'b0;
        repeat (4) @(negedge clk);

        // Reset in the middle of a frame with bytes queued
        do_reset();
        for (int i = 0; i < 6; i++) begin
            write_byte(8'($urandom));
        end
        check("t6_count5", 32'(bus.count), 5);
        check("t6_sending", 32'(bus.tx_start), 1);
        reset = 1'b1;
        @(negedge clk);
        check("t6_start", 32'(bus.tx_start), 0);
        check("t6_count", 32'(bus.count), 0);
        check("t6_empty", 32'(bus.empty), 1);
        check("t6_ovf", 32'(bus.overflow), 0);
        check("t6_busy", 32'(bus.busy), 0);
        reset = 1'b0;
        snap = launches;
        man_done = 1'b1;
        repeat (2) @(negedge clk);
        man_done = 1'b0;
        repeat (4) @(negedge clk);
        check("t6_no_pop", 32'(launches), 32'(snap));
        check("t6_still_idle", 32'(bus.busy), 0);
        check("t6_still_empty", 32'(bus.count), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
